vga_axil_initiator: RTL and testbench

AXI4-Lite manager that turns single register-access requests into AXI4-Lite write or read transactions toward the VGA control subordinate. Used by host-side bridges and by the integration bench to program timing/framebuffer registers. One transaction outstanding at a time; each request yields exactly one response carrying BRESP/RRESP and, for reads, RDATA. Address/data/response widths match the codebase AXI-Lite package (32/32/2).

---
 rtl/vga_axil_initiator.sv | 161 ++++++++++++++++
 tb/tb_vga_axil_initiator.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_axil_initiator.sv
// AXI4-Lite manager: turns one register-access request at a time into an AXI4-Lite
// write (AW+W/B) or read (AR/R) toward the VGA control subordinate.
module vga_axil_initiator #(
  parameter int AXIL_ADDR_WIDTH = 32,
  parameter int AXIL_DATA_WIDTH = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_we_i,
  input  logic [AXIL_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [AXIL_DATA_WIDTH-1:0]   req_wdata_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic                         rsp_we_o,
  output logic [AXIL_DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic [1:0]                   rsp_resp_o,
  output logic                         m_awvalid_o,
  input  logic                         m_awready_i,
  output logic [AXIL_ADDR_WIDTH-1:0]   m_awaddr_o,
  output logic [2:0]                   m_awprot_o,
  output logic                         m_wvalid_o,
  input  logic                         m_wready_i,
  output logic [AXIL_DATA_WIDTH-1:0]   m_wdata_o,
  output logic [AXIL_DATA_WIDTH/8-1:0] m_wstrb_o,
  input  logic                         m_bvalid_i,
  output logic                         m_bready_o,
  input  logic [1:0]                   m_bresp_i,
  output logic                         m_arvalid_o,
  input  logic                         m_arready_i,
  output logic [AXIL_ADDR_WIDTH-1:0]   m_araddr_o,
  output logic [2:0]                   m_arprot_o,
  input  logic                         m_rvalid_i,
  output logic                         m_rready_o,
  input  logic [AXIL_DATA_WIDTH-1:0]   m_rdata_i,
  input  logic [1:0]                   m_rresp_i
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4,
    RSP          = 3'd5
  } state_e;

  state_e                       state_q, state_d;
  logic [AXIL_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [AXIL_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                         we_q, we_d;
  logic                         aw_done_q, aw_done_d;
  logic                         w_done_q, w_done_d;
  logic                         rsp_we_q, rsp_we_d;
  logic [AXIL_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                   rsp_resp_q, rsp_resp_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_we_q    <= rsp_we_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_we_d    = rsp_we_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    m_awvalid_o = 1'b0;
    m_wvalid_o  = 1'b0;
    m_bready_o  = 1'b0;
    m_arvalid_o = 1'b0;
    m_rready_o  = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          addr_d    = req_addr_i;
          wdata_d   = req_wdata_i;
          we_d      = req_we_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_we_i ? WR_ADDR_DATA : RD_ADDR;
        end
      end
      WR_ADDR_DATA: begin
        // AW and W complete independently; leave once both have handshaken
        m_awvalid_o = !aw_done_q;
        m_wvalid_o  = !w_done_q;
        if (!aw_done_q && m_awready_i) aw_done_d = 1'b1;
        if (!w_done_q && m_wready_i)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)     state_d   = WR_RESP;
      end
      WR_RESP: begin
        m_bready_o = 1'b1;
        if (m_bvalid_i) begin
          rsp_we_d    = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_bresp_i;
          state_d     = RSP;
        end
      end
      RD_ADDR: begin
        m_arvalid_o = 1'b1;
        if (m_arready_i) state_d = RD_DATA;
      end
      RD_DATA: begin
        m_rready_o = 1'b1;
        if (m_rvalid_i) begin
          rsp_we_d    = 1'b0;
          rsp_rdata_d = m_rdata_i;
          rsp_resp_d  = m_rresp_i;
          state_d     = RSP;
        end
      end
      RSP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_awaddr_o  = addr_q;
  assign m_araddr_o  = addr_q;
  assign m_wdata_o   = wdata_q;
  assign m_wstrb_o   = '1;
  assign m_awprot_o  = 3'b000;
  assign m_arprot_o  = 3'b000;
  assign rsp_we_o    = rsp_we_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_resp_o  = rsp_resp_q;

endmodule

// File: tb/tb_vga_axil_initiator.sv
// Self-checking bench: behavioural AXI-Lite subordinate with configurable/random stalls,
// directed latency/protocol cases, and a random write/read run against a memory model.
module tb_vga_axil_initiator;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_we_o;
  logic [31:0] rsp_rdata_o;
  logic [1:0]  rsp_resp_o;
  logic        m_awvalid_o, m_awready_i;
  logic [31:0] m_awaddr_o;
  logic [2:0]  m_awprot_o, m_arprot_o;
  logic        m_wvalid_o, m_wready_i;
  logic [31:0] m_wdata_o;
  logic [3:0]  m_wstrb_o;
  logic        m_bvalid_i, m_bready_o;
  logic [1:0]  m_bresp_i;
  logic        m_arvalid_o, m_arready_i;
  logic [31:0] m_araddr_o;
  logic        m_rvalid_i, m_rready_o;
  logic [31:0] m_rdata_i;
  logic [1:0]  m_rresp_i;

  vga_axil_initiator #(.AXIL_ADDR_WIDTH(32), .AXIL_DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_we_o(rsp_we_o),
    .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o),
    .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i), .m_awaddr_o(m_awaddr_o),
    .m_awprot_o(m_awprot_o),
    .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i), .m_wdata_o(m_wdata_o),
    .m_wstrb_o(m_wstrb_o),
    .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o), .m_bresp_i(m_bresp_i),
    .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i), .m_araddr_o(m_araddr_o),
    .m_arprot_o(m_arprot_o),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o), .m_rdata_i(m_rdata_i),
    .m_rresp_i(m_rresp_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // subordinate configuration
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit          rand_dly = 0;
  bit          force_en = 0;
  logic [1:0]  force_resp = 2'b00;
  logic [31:0] force_rdata = '0;
  logic [31:0] smem [logic [31:0]];
  int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;

  function automatic logic [1:0] resp_of(input logic [31:0] a);
    return (a[7:4] == 4'hF) ? 2'b10 : 2'b00;
  endfunction

  function automatic int pick(input int d);
    return rand_dly ? int'($urandom_range(0, 3)) : d;
  endfunction

  // behavioural subordinate: acts #1 after each edge on what handshook at that edge
  initial begin
    logic s_awv, s_awr, s_wv, s_wr, s_bv, s_br, s_arv, s_arr, s_rv, s_rr;
    logic [31:0] s_awaddr, s_wdata, s_araddr, wr_addr, wr_data, rd_addr;
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit aw_got, w_got, b_pend, r_pend;
    {s_awv, s_awr, s_wv, s_wr, s_bv, s_br, s_arv, s_arr, s_rv, s_rr} = '0;
    s_awaddr = '0; s_wdata = '0; s_araddr = '0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    aw_cnt = -1; w_cnt = -1; ar_cnt = -1; b_cnt = 0; r_cnt = 0;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    m_awready_i = 0; m_wready_i = 0; m_arready_i = 0;
    m_bvalid_i = 0; m_bresp_i = 0; m_rvalid_i = 0; m_rdata_i = '0; m_rresp_i = 0;
    forever begin
      @(posedge clk_i); #1;
      if (!rst_ni) begin
        {s_awv, s_awr, s_wv, s_wr, s_bv, s_br, s_arv, s_arr, s_rv, s_rr} = '0;
        aw_cnt = -1; w_cnt = -1; ar_cnt = -1;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        m_awready_i = 0; m_wready_i = 0; m_arready_i = 0;
        m_bvalid_i = 0; m_rvalid_i = 0;
      end else begin
        if (s_bv && s_br) begin b_pend = 0; n_b++; end
        if (s_rv && s_rr) begin r_pend = 0; n_r++; end
        if (s_awv) begin
          if (s_awr) begin
            chk("aw_drop", m_awvalid_o, 0);
            wr_addr = s_awaddr; aw_got = 1; aw_cnt = -1; n_aw++;
          end else begin
            chk("aw_hold", m_awvalid_o, 1);
            chk("awaddr_hold", m_awaddr_o, s_awaddr);
          end
        end
        if (s_wv) begin
          if (s_wr) begin
            chk("w_drop", m_wvalid_o, 0);
            wr_data = s_wdata; w_got = 1; w_cnt = -1; n_w++;
          end else begin
            chk("w_hold", m_wvalid_o, 1);
            chk("wdata_hold", m_wdata_o, s_wdata);
          end
        end
        if (s_arv) begin
          if (s_arr) begin
            chk("ar_drop", m_arvalid_o, 0);
            rd_addr = s_araddr; ar_cnt = -1; n_ar++;
            r_pend = 1; r_cnt = pick(r_dly);
            m_rdata_i = force_en ? force_rdata : (smem.exists(rd_addr) ? smem[rd_addr] : 32'h0);
            m_rresp_i = force_en ? force_resp : resp_of(rd_addr);
          end else begin
            chk("ar_hold", m_arvalid_o, 1);
            chk("araddr_hold", m_araddr_o, s_araddr);
          end
        end
        if (aw_got && w_got) begin
          smem[wr_addr] = wr_data;
          m_bresp_i = force_en ? force_resp : resp_of(wr_addr);
          aw_got = 0; w_got = 0; b_pend = 1; b_cnt = pick(b_dly);
        end
        if (m_awvalid_o) begin
          if (aw_cnt < 0) aw_cnt = pick(aw_dly);
          m_awready_i = (aw_cnt == 0);
          if (aw_cnt > 0) aw_cnt--;
        end else m_awready_i = 0;
        if (m_wvalid_o) begin
          if (w_cnt < 0) w_cnt = pick(w_dly);
          m_wready_i = (w_cnt == 0);
          if (w_cnt > 0) w_cnt--;
        end else m_wready_i = 0;
        if (m_arvalid_o) begin
          if (ar_cnt < 0) ar_cnt = pick(ar_dly);
          m_arready_i = (ar_cnt == 0);
          if (ar_cnt > 0) ar_cnt--;
        end else m_arready_i = 0;
        if (b_pend) begin
          m_bvalid_i = (b_cnt == 0);
          if (b_cnt > 0) b_cnt--;
        end else m_bvalid_i = 0;
        if (r_pend) begin
          m_rvalid_i = (r_cnt == 0);
          if (r_cnt > 0) r_cnt--;
        end else m_rvalid_i = 0;
        s_awv = m_awvalid_o; s_awr = m_awready_i; s_awaddr = m_awaddr_o;
        s_wv  = m_wvalid_o;  s_wr  = m_wready_i;  s_wdata  = m_wdata_o;
        s_arv = m_arvalid_o; s_arr = m_arready_i; s_araddr = m_araddr_o;
        s_bv  = m_bvalid_i;  s_br  = m_bready_o;
        s_rv  = m_rvalid_i;  s_rr  = m_rready_o;
      end
    end
  end

  task automatic step();
    @(posedge clk_i); #2;
  endtask

  int acc_cyc, hs_cyc;

  task automatic send_req(input logic we, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    req_valid_i = 1; req_we_i = we; req_addr_i = a; req_wdata_i = d;
    while (!req_ready_o && n < 50) begin step(); n++; end
    chk("req_accept", {31'b0, req_ready_o}, 1);
    acc_cyc = cyc;
    step();
    req_valid_i = 0; req_we_i = 0; req_addr_i = '0; req_wdata_i = '0;
  endtask

  task automatic wait_rsp(input int hold, output logic we, output logic [31:0] rdata,
                          output logic [1:0] resp, output int lat);
    int n;
    n = 0;
    while (!rsp_valid_o && n < 100) begin step(); n++; end
    chk("rsp_valid", {31'b0, rsp_valid_o}, 1);
    lat = cyc - acc_cyc;
    we = rsp_we_o; rdata = rsp_rdata_o; resp = rsp_resp_o;
    chk("req_ready_in_rsp", {31'b0, req_ready_o}, 0);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("rsp_hold_valid", {31'b0, rsp_valid_o}, 1);
      chk("rsp_hold_rdata", rsp_rdata_o, rdata);
      chk("rsp_hold_resp", {30'b0, rsp_resp_o}, {30'b0, resp});
      chk("req_ready_blocked", {31'b0, req_ready_o}, 0);
    end
    rsp_ready_i = 1;
    hs_cyc = cyc;
    step();
    rsp_ready_i = 0;
    chk("rsp_drop", {31'b0, rsp_valid_o}, 0);
    chk("req_ready_after_rsp", {31'b0, req_ready_o}, 1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  logic        r_we;
  logic [31:0] r_rdata;
  logic [1:0]  r_resp;
  int          lat, cnt, nb0, naw0, nw0, nar0, nr0, nwr, nrd;
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] a, d, exp_d;

  initial begin
    rst_ni = 0; req_valid_i = 0; req_we_i = 0; req_addr_i = '0; req_wdata_i = '0;
    rsp_ready_i = 0;
    #1;
    chk("rst_req_ready", {31'b0, req_ready_o}, 1);
    chk("rst_valids", {27'b0, m_awvalid_o, m_wvalid_o, m_arvalid_o, rsp_valid_o, 1'b0}, 0);
    chk("rst_readies", {30'b0, m_bready_o, m_rready_o}, 0);
    chk("rst_rsp", {rsp_rdata_o[29:0], rsp_resp_o} | {31'b0, rsp_we_o}, 0);
    chk("rst_addr", m_awaddr_o | m_wdata_o, 0);
    repeat (3) @(posedge clk_i);
    #3 rst_ni = 1;
    step();

    // zero-wait write
    send_req(1, 32'h0000_0010, 32'hDEAD_BEEF);
    chk("wr_awvalid", {31'b0, m_awvalid_o}, 1);
    chk("wr_wvalid", {31'b0, m_wvalid_o}, 1);
    chk("wr_awaddr", m_awaddr_o, 32'h0000_0010);
    chk("wr_wdata", m_wdata_o, 32'hDEAD_BEEF);
    chk("wr_wstrb", {28'b0, m_wstrb_o}, 32'hF);
    chk("wr_prot", {26'b0, m_awprot_o, m_arprot_o}, 0);
    step();
    chk("wr_bready", {31'b0, m_bready_o}, 1);
    wait_rsp(0, r_we, r_rdata, r_resp, lat);
    chk("wr_lat", lat, 3);
    chk("wr_rsp_we", {31'b0, r_we}, 1);
    chk("wr_rsp_resp", {30'b0, r_resp}, 0);
    chk("wr_rsp_rdata", r_rdata, 0);

    // AW stalled 3 cycles, W immediate
    aw_dly = 3; nb0 = n_b;
    send_req(1, 32'h0000_0020, 32'h0BAD_F00D);
    chk("aws_wvalid_n1", {31'b0, m_wvalid_o}, 1);
    step();
    chk("aws_wvalid_drop", {31'b0, m_wvalid_o}, 0);
    cnt = 1;
    while (m_awvalid_o && cnt < 20) begin cnt++; step(); end
    chk("aws_aw_cycles", cnt, 4);
    wait_rsp(0, r_we, r_rdata, r_resp, lat);
    chk("aws_b_count", n_b - nb0, 1);
    chk("aws_rsp_we", {31'b0, r_we}, 1);
    aw_dly = 0;

    // read with SLVERR after 2-cycle R delay
    force_en = 1; force_resp = 2'b10; force_rdata = 32'h1234_5678; r_dly = 2;
    send_req(0, 32'h0000_0004, 32'hFFFF_FFFF);
    chk("rd_arvalid", {31'b0, m_arvalid_o}, 1);
    chk("rd_araddr", m_araddr_o, 32'h0000_0004);
    wait_rsp(0, r_we, r_rdata, r_resp, lat);
    chk("rd_lat", lat, 5);
    chk("rd_rdata", r_rdata, 32'h1234_5678);
    chk("rd_resp", {30'b0, r_resp}, 2);
    chk("rd_we", {31'b0, r_we}, 0);
    force_en = 0; r_dly = 0;

    // response back-pressure with a pending request
    send_req(0, 32'h0000_0010, 32'h0);
    req_valid_i = 1; req_we_i = 1; req_addr_i = 32'h0000_0030; req_wdata_i = 32'hCAFE_0001;
    wait_rsp(5, r_we, r_rdata, r_resp, lat);
    chk("bp_lat", lat, 3);
    chk("bp_rdata", r_rdata, 32'hDEAD_BEEF);
    send_req(1, 32'h0000_0030, 32'hCAFE_0001);
    chk("bp_next_accept", acc_cyc - hs_cyc, 1);
    wait_rsp(0, r_we, r_rdata, r_resp, lat);
    chk("bp_wr_we", {31'b0, r_we}, 1);

    // random write/read pairs against a memory model
    smem.delete();
    rand_dly = 1;
    nb0 = n_b; naw0 = n_aw; nw0 = n_w; nar0 = n_ar; nr0 = n_r; nwr = 0; nrd = 0;
    for (int i = 0; i < 1000; i++) begin
      a = 32'($urandom_range(0, 15)) << 4;
      d = $urandom;
      model_mem[a] = d;
      send_req(1, a, d); nwr++;
      wait_rsp($urandom_range(0, 2), r_we, r_rdata, r_resp, lat);
      chk("rnd_wr_we", {31'b0, r_we}, 1);
      chk("rnd_wr_resp", {30'b0, r_resp}, {30'b0, resp_of(a)});
      chk("rnd_wr_rdata", r_rdata, 0);
      a = 32'($urandom_range(0, 15)) << 4;
      exp_d = model_mem.exists(a) ? model_mem[a] : 32'h0;
      send_req(0, a, $urandom); nrd++;
      wait_rsp($urandom_range(0, 2), r_we, r_rdata, r_resp, lat);
      chk("rnd_rd_we", {31'b0, r_we}, 0);
      chk("rnd_rd_data", r_rdata, exp_d);
      chk("rnd_rd_resp", {30'b0, r_resp}, {30'b0, resp_of(a)});
    end
    chk("rnd_aw_count", n_aw - naw0, nwr);
    chk("rnd_w_count", n_w - nw0, nwr);
    chk("rnd_b_count", n_b - nb0, nwr);
    chk("rnd_ar_count", n_ar - nar0, nrd);
    chk("rnd_r_count", n_r - nr0, nrd);
    rand_dly = 0;

    // reset while waiting for B
    b_dly = 8;
    send_req(1, 32'h0000_0050, 32'h5555_AAAA);
    cnt = 0;
    while (!m_bready_o && cnt < 20) begin step(); cnt++; end
    chk("rst_mid_bready", {31'b0, m_bready_o}, 1);
    #2 rst_ni = 0;
    #1;
    chk("rst_mid_valids", {28'b0, m_awvalid_o, m_wvalid_o, m_arvalid_o, rsp_valid_o}, 0);
    chk("rst_mid_readies", {30'b0, m_bready_o, m_rready_o}, 0);
    chk("rst_mid_req_ready", {31'b0, req_ready_o}, 1);
    chk("rst_mid_rsp_we", {31'b0, rsp_we_o}, 0);
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1;
    b_dly = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst_no_rsp", {31'b0, rsp_valid_o}, 0);
      chk("rst_idle_ready", {31'b0, req_ready_o}, 1);
    end
    send_req(1, 32'h0000_0060, 32'h600D_D00D);
    wait_rsp(0, r_we, r_rdata, r_resp, lat);
    chk("post_rst_wr_lat", lat, 3);
    send_req(0, 32'h0000_0060, 32'h0);
    wait_rsp(0, r_we, r_rdata, r_resp, lat);
    chk("post_rst_rd_data", r_rdata, 32'h600D_D00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
